// File: rtl/fsm_trace_buffer.sv
// Transition tracer for an FSM state code: each change of the observed state is
// queued as {prev_state, new_state, timestamp} in a show-ahead FIFO drained by a sink.
module fsm_trace_buffer #(
  parameter int NAME    = 0,
  parameter int STATE_W = 4,
  parameter int TS_W    = 16,
  parameter int DEPTH   = 8
) (
  input  logic                      aclk,
  input  logic                      srst,
  input  logic                      en,
  input  logic [STATE_W-1:0]        state_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [2*STATE_W+TS_W-1:0] out_data,
  output logic [31:0]               out_name,
  output logic                      full,
  output logic [7:0]                drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 2*STATE_W + TS_W;

  logic [TS_W-1:0]    ts_reg;
  logic [STATE_W-1:0] last_state_reg;
  logic [AW-1:0]      rd_ptr_reg;
  logic [AW-1:0]      wr_ptr_reg;
  logic [AW:0]        count_reg;
  logic [AW:0]        count_next;
  logic [7:0]         drop_reg;
  logic [EW-1:0]      mem [DEPTH];

  logic push_req;
  logic pop;
  logic push;

  assign out_valid = (count_reg != '0);
  assign full      = (count_reg == (AW+1)'(DEPTH));
  assign out_data  = mem[rd_ptr_reg];
  assign out_name  = 32'(NAME);
  assign drop_cnt  = drop_reg;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push.
  always_comb begin
    push_req = en && (state_in != last_state_reg);
    pop      = out_valid && out_ready;
    push     = push_req && (!full || pop);
  end

  always_comb begin
    count_next = count_reg;
    if (push && !pop) begin
      count_next = count_reg + (AW+1)'(1);
    end else if (!push && pop) begin
      count_next = count_reg - (AW+1)'(1);
    end
  end

  always_ff @(posedge aclk) begin
    if (srst) begin
      ts_reg         <= '0;
      last_state_reg <= '0;
      rd_ptr_reg     <= '0;
      wr_ptr_reg     <= '0;
      count_reg      <= '0;
      drop_reg       <= '0;
    end else begin
      ts_reg    <= ts_reg + TS_W'(1);
      count_reg <= count_next;
      // Tracks the sampled state even when the event is dropped.
      if (en) begin
        last_state_reg <= state_in;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (push_req && !push && (drop_reg != 8'hFF)) begin
        drop_reg <= drop_reg + 8'd1;
      end
    end
  end

  // Storage has no reset; occupancy is governed solely by count_reg.
  always_ff @(posedge aclk) begin
    if (push && !srst) begin
      mem[wr_ptr_reg] <= {last_state_reg, state_in, ts_reg};
    end
  end

endmodule

// File: tb/tb_fsm_trace_buffer.sv
// Directed bench for fsm_trace_buffer: reset, single transition, enable masking,
// overflow, full push/pop and timestamp wrap on a narrow-timestamp instance.
module tb_fsm_trace_buffer;

  logic        aclk = 1'b0;
  logic        srst;
  logic        en;
  logic [3:0]  state_in;
  logic        out_ready;
  logic        out_valid;
  logic [23:0] out_data;
  logic [31:0] out_name;
  logic        full;
  logic [7:0]  drop_cnt;

  logic        out_valid4;
  logic [11:0] out_data4;
  logic [31:0] out_name4;
  logic        full4;
  logic [7:0]  drop_cnt4;

  int n_chk  = 0;
  int n_fail = 0;
  int tb_ts  = 0;
  logic [3:0]  last_s;
  logic [23:0] exp_q [$];

  always #5 aclk = ~aclk;

  // Reference timestamp: value the DUT timestamp register holds after each edge.
  always @(posedge aclk) begin
    if (srst) tb_ts <= 0;
    else      tb_ts <= tb_ts + 1;
  end

  fsm_trace_buffer #(.NAME(32'h1234), .STATE_W(4), .TS_W(16), .DEPTH(8)) dut (
    .aclk(aclk), .srst(srst), .en(en), .state_in(state_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_name(out_name), .full(full), .drop_cnt(drop_cnt)
  );

  fsm_trace_buffer #(.NAME(7), .STATE_W(4), .TS_W(4), .DEPTH(8)) dut4 (
    .aclk(aclk), .srst(srst), .en(en), .state_in(state_in),
    .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
    .out_name(out_name4), .full(full4), .drop_cnt(drop_cnt4)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic drive_state(input logic [3:0] s, input bit store);
    logic [15:0] t;
    t = 16'(tb_ts);
    state_in = s;
    step();
    if (store) exp_q.push_back({last_s, s, t});
    last_s = s;
  endtask

  task automatic drain(input int n);
    logic [23:0] e;
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      chk("drain_valid", 64'(out_valid), 64'd1);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 24'hxxxxxx;
      chk("drain_data", 64'(out_data), 64'(e));
      step();
    end
    out_ready = 1'b0;
  endtask

  initial begin
    logic [15:0] t;
    srst = 1'b1; en = 1'b1; state_in = 4'd5; out_ready = 1'b0;
    last_s = 4'd0;

    // Reset holds everything clear despite en=1 and a nonzero state
    repeat (3) step();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    chk("name", 64'(out_name), 64'h1234);
    chk("name4", 64'(out_name4), 64'd7);

    srst = 1'b0;
    drive_state(4'd5, 1'b1);
    chk("first_valid", 64'(out_valid), 64'd1);
    chk("first_data", 64'(out_data), 64'h050000);
    drain(1);
    chk("first_popped", 64'(out_valid), 64'd0);

    // Single transition 0->3 sampled at timestamp 20
    drive_state(4'd0, 1'b1);
    drain(1);
    for (int i = 0; i < 100 && tb_ts != 20; i++) step();
    chk("ts_reach20", 64'(tb_ts), 64'd20);
    drive_state(4'd3, 1'b1);
    chk("single_valid", 64'(out_valid), 64'd1);
    chk("single_data", 64'(out_data), 64'h030014);
    drain(1);
    chk("single_popped", 64'(out_valid), 64'd0);

    // Masking: en=0 ignores toggles, last_state holds at 1
    drive_state(4'd1, 1'b1);
    drain(1);
    en = 1'b0;
    state_in = 4'd2; step();
    chk("mask_valid_a", 64'(out_valid), 64'd0);
    state_in = 4'd1; step();
    state_in = 4'd2; step();
    chk("mask_valid_b", 64'(out_valid), 64'd0);
    t = 16'(tb_ts);
    en = 1'b1;
    step();
    chk("unmask_valid", 64'(out_valid), 64'd1);
    chk("unmask_data", 64'(out_data), 64'({4'd1, 4'd2, t}));
    step();
    chk("stall_valid", 64'(out_valid), 64'd1);
    chk("stall_data", 64'(out_data), 64'({4'd1, 4'd2, t}));
    out_ready = 1'b1; step(); out_ready = 1'b0;
    chk("unmask_popped", 64'(out_valid), 64'd0);
    last_s = 4'd2;

    // Overflow: 10 transitions into 8 slots
    for (int k = 3; k <= 12; k++) drive_state(4'(k), k <= 10);
    chk("ovf_full", 64'(full), 64'd1);
    chk("ovf_drop", 64'(drop_cnt), 64'd2);
    drain(8);
    chk("ovf_empty", 64'(out_valid), 64'd0);
    drive_state(4'd13, 1'b1);
    chk("post_drop_prev", 64'(out_data[23:20]), 64'd12);
    drain(1);

    // Full with simultaneous push and pop
    drive_state(4'd14, 1'b1);
    drive_state(4'd15, 1'b1);
    for (int k = 0; k <= 5; k++) drive_state(4'(k), 1'b1);
    chk("pp_full_before", 64'(full), 64'd1);
    chk("pp_head", 64'(out_data), 64'({4'd13, 4'd14, exp_q[0][15:0]}));
    out_ready = 1'b1;
    drive_state(4'd6, 1'b1);
    void'(exp_q.pop_front());
    out_ready = 1'b0;
    chk("pp_drop", 64'(drop_cnt), 64'd2);
    chk("pp_full_after", 64'(full), 64'd1);
    drain(8);
    chk("pp_empty", 64'(out_valid), 64'd0);

    // Reset mid-drain discards stored events
    for (int k = 7; k <= 11; k++) drive_state(4'(k), 1'b1);
    chk("mid_valid", 64'(out_valid), 64'd1);
    chk("mid_full", 64'(full), 64'd0);
    srst = 1'b1; state_in = 4'd0;
    step();
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_drop", 64'(drop_cnt), 64'd0);
    step();
    srst = 1'b0;
    exp_q.delete();
    last_s = 4'd0;

    // Timestamp wrap on the 4-bit instance: ts 17 wraps to 1
    for (int i = 0; i < 100 && tb_ts != 17; i++) step();
    chk("ts_reach17", 64'(tb_ts), 64'd17);
    chk("idle_valid", 64'(out_valid), 64'd0);
    drive_state(4'd9, 1'b1);
    chk("wrap_valid4", 64'(out_valid4), 64'd1);
    chk("wrap_data4", 64'(out_data4), 64'h091);
    chk("wrap_full4", 64'(full4), 64'd0);
    chk("wrap_drop4", 64'(drop_cnt4), 64'd0);
    chk("nowrap_data", 64'(out_data), 64'h090011);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/fsm_trace_buffer.md
Name: fsm_trace_buffer

Overview:
- Sits directly downstream of an `fsm` instance and watches its state code.
- Each state transition is recorded as an event {previous state, new state, timestamp} into an internal FIFO.
- A logger sink drains the FIFO over a valid/ready interface.
- Used in simulation and on hardware to trace FSM activity without stalling the FSM.

Parameters:
- NAME, 0, instance identifier; carried unchanged on out_name for the logger.
- STATE_W, 4, width of the observed state code.
- TS_W, 16, width of the free-running timestamp counter.
- DEPTH, 8, number of FIFO entries; must be a power of 2, at least 2.

Ports:
- aclk  input  1  clock; all logic is on the rising edge.
- srst  input  1  reset; synchronous, active-high.
- en  input  1  tracing enable; when low, state_in is ignored.
- state_in  input  STATE_W  current state code of the observed fsm.
- out_valid  output  1  the FIFO head holds an event.
- out_ready  input  1  the sink accepts the head event.
- out_data  output  2*STATE_W+TS_W  head event, packed {prev_state, new_state, timestamp}, MSB first.
- out_name  output  32  constant NAME.
- full  output  1  the FIFO holds DEPTH entries.
- drop_cnt  output  8  count of events lost to overflow; saturates at 255.

Behaviour:
- Reset (srst high at an edge) sets: timestamp=0, last_state=0, rd_ptr=0, wr_ptr=0, count=0, drop_cnt=0.
  - After reset: out_valid=0, full=0.
  - out_data is don't-care while out_valid=0.
  - srst overrides all other inputs in the same cycle.
  - A reset mid-operation discards all stored events.
- Timestamp counter:
  - Increments every cycle, independent of en.
  - Wraps from 2^TS_W-1 to 0 with no flag.
- Change detect, evaluated at each edge:
  - push_req = en && (state_in != last_state).
  - last_state <= state_in whenever en=1; it holds when en=0.
  - The recorded event is {last_state, state_in, timestamp}, using register values before this edge's update.
- Latency: a state_in change sampled at edge N gives out_valid=1 immediately after edge N, provided the FIFO was empty (one-cycle latency).
- FIFO is show-ahead:
  - out_valid = (count != 0).
  - out_data = mem[rd_ptr], combinational from storage.
  - Pointers are $clog2(DEPTH) bits and wrap naturally.
  - count is $clog2(DEPTH)+1 bits.
- Pop: pop = out_valid && out_ready.
  - rd_ptr advances and count decrements.
  - out_ready while out_valid=0 has no effect.
- Push acceptance: push = push_req && (!full || pop).
  - When accepted, the entry is written at wr_ptr, wr_ptr advances and count increments.
- Simultaneous push and pop: count is unchanged and both pointers advance.
  - At full, this is lossless.
  - At count=1, out_valid stays 1 and the new head is the pushed event.
- Overflow (push_req && full && !pop):
  - The event is dropped.
  - drop_cnt increments, saturating at 255.
  - Stored entries are not overwritten.
  - last_state still updates, so the next recorded event's prev_state reflects the true sampled state.
- Handshake rule: out_data and out_valid must stay stable while out_valid=1 and out_ready=0.
- full = (count == DEPTH), registered-equivalent (derived from the count register).
- No combinational path from out_ready to out_valid.

Test Plan:
- Reset values: hold srst 3 cycles, state_in=5, en=1 → out_valid=0, full=0, drop_cnt=0. On the first post-reset edge with state_in=5, event {0,5,ts=0} appears.
- Single transition: en=1, state_in goes 0→3 sampled at timestamp 20, out_ready=1 → one cycle later out_valid=1, out_data={0,3,20}. out_valid drops the cycle after it is accepted.
- Masking:
  - With en=0, toggle state_in 1→2→1 → no events.
  - Raise en with state_in=2 and last_state=1 → one event {1,2,ts}.
- Overflow: DEPTH=8, out_ready=0, 10 distinct transitions → full=1, drop_cnt=2.
  - Draining yields the first 8 events in order, each with a correct prev_state chain.
  - The first event after the drops carries prev_state equal to the last sampled state.
- Full with simultaneous push/pop: FIFO full, out_ready=1 plus a new transition in the same cycle → drop_cnt unchanged, full stays 1, the new event lands at the tail.
- Reset mid-drain and timestamp wrap:
  - Assert srst with 5 entries stored → out_valid=0 next cycle.
  - With TS_W=4, a transition at cycle 17 after reset records ts=1.
